// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per clock,
// with valid/ready handshakes on both sides and a registered zero flag for the ALU.
module logic_unit_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   generate
      if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("logic_unit_serial: SLICE must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  opA_q;
   logic [WIDTH-1:0]  opB_q;
   logic [1:0]        opSel_q;
   logic [WIDTH-1:0]  result_q;
   logic              nonZero_q;
   logic              zero_q;
   logic [IDXW-1:0]   idx_q;
   logic [IDXW-1:0]   idx_d;
   logic              outValid_q;
   logic              inReady_q;

   logic [SLICE-1:0]  sliceA;
   logic [SLICE-1:0]  sliceB;
   logic [SLICE-1:0]  sliceRes;

   // The slice currently addressed by idx_q and its op result; no inter-slice dependency.
   always_comb begin
      sliceA = opA_q[int'(idx_q) * SLICE +: SLICE];
      sliceB = opB_q[int'(idx_q) * SLICE +: SLICE];
      idx_d  = idx_q + IDXW'(1);
      case (opSel_q)
         2'b00:   sliceRes = sliceA & sliceB;
         2'b01:   sliceRes = sliceA | sliceB;
         2'b10:   sliceRes = sliceA ^ sliceB;
         default: sliceRes = ~(sliceA | sliceB);
      endcase
   end

   // Control FSM plus datapath registers; every output comes straight from a flop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         opSel_q    <= 2'b00;
         result_q   <= '0;
         nonZero_q  <= 1'b0;
         zero_q     <= 1'b0;
         idx_q      <= '0;
         outValid_q <= 1'b0;
         inReady_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  opA_q     <= A;
                  opB_q     <= B;
                  opSel_q   <= op;
                  result_q  <= '0;
                  nonZero_q <= 1'b0;
                  idx_q     <= '0;
                  inReady_q <= 1'b0;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               result_q[int'(idx_q) * SLICE +: SLICE] <= sliceRes;
               nonZero_q <= nonZero_q | (|sliceRes);
               if (idx_q == LAST_IDX) begin
                  // Fold the final slice in directly so zero is ready with out_valid.
                  zero_q     <= ~(nonZero_q | (|sliceRes));
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  idx_q <= idx_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               outValid_q <= 1'b0;
               inReady_q  <= 1'b1;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign o         = result_q;
   assign zero      = zero_q;

endmodule
